lfsr_challenge_gen: RTL and testbench

//  Parametrised LFSR challenge generator for serial PUF evaluation. Loads a seed, then issues a

---
 rtl/lfsr_pkg.sv | 29 ++
 rtl/lfsr_core.sv | 37 +++
 rtl/lfsr_challenge_gen.sv | 138 +++++++++++++
 tb/tb_lfsr_challenge_gen.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the LFSR challenge generator.
// Optional lockup recovery in the top level is enabled by defining LFSR_LOCKUP_RECOVER_EN.
package lfsr_pkg;

    // Burst controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } lfsr_state_e;

    // Widest register the next-state helper can handle.
    localparam int LFSR_MAX_W = 64;

    // One Fibonacci step: shift left and insert the parity of the tapped bits at bit 0.
    // The result is masked to 'width' bits, so callers can truncate it safely.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] state,
        input logic [LFSR_MAX_W-1:0] taps,
        input int                    width
    );
        logic [LFSR_MAX_W-1:0] mask;
        logic                  feedback;
        mask     = {LFSR_MAX_W{1'b1}} >> (LFSR_MAX_W - width);
        feedback = ^(state & taps & mask);
        return ((state << 1) & mask) | {{(LFSR_MAX_W-1){1'b0}}, feedback};
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// LFSR state register with load and advance controls.
// Load has priority over advance; the register holds when neither is asserted.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] TAPS        = 8'h8E,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             advance,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] next_state;

    // Next LFSR value from the shared step function.
    always_comb begin
        next_state = WIDTH'(lfsr_next(LFSR_MAX_W'(state), LFSR_MAX_W'(TAPS), WIDTH));
    end

    // State register: reset to the recovery seed, then load or step.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state <= RESET_VALUE;
        end else if (load) begin
            state <= load_value;
        end else if (advance) begin
            state <= next_state;
        end
    end

endmodule

// File: rtl/lfsr_challenge_gen.sv
// LFSR challenge generator: seeds an LFSR, then issues bounded bursts of challenges over a
// valid/ready handshake with abort and a one-cycle done pulse.
// Define LFSR_LOCKUP_RECOVER_EN to replace an all-zero seed with DEFAULT_SEED and expose lockup_fixed.
module lfsr_challenge_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] TAPS         = 8'h8E,
    parameter int               CNT_W        = 16,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] seed,
    input  logic             seed_load,
    input  logic             start,
    input  logic [CNT_W-1:0] burst_len,
    input  logic             abort,
    output logic [WIDTH-1:0] challenge,
    output logic             challenge_valid,
    input  logic             challenge_ready,
    output logic             busy,
    output logic             done,
`ifdef LFSR_LOCKUP_RECOVER_EN
    output logic             lockup_fixed,
`endif
    output logic [CNT_W-1:0] issued_count
);

    lfsr_state_e      state_q, state_d;
    logic [CNT_W-1:0] remaining_q;
    logic [CNT_W-1:0] issued_q;
    logic [WIDTH-1:0] load_value;
    logic             seed_accept;
    logic             start_accept;
    logic             handshake;
    logic             last_handshake;

    // Controller commands are only honoured in IDLE; a seed load shadows a same-cycle start.
    assign seed_accept    = (state_q == IDLE) && seed_load;
    assign start_accept   = (state_q == IDLE) && start && !seed_load;
    assign handshake      = (state_q == RUN) && challenge_ready;
    assign last_handshake = handshake && (remaining_q == CNT_W'(1));

`ifdef LFSR_LOCKUP_RECOVER_EN
    // An all-zero seed would freeze the LFSR, so substitute the recovery seed.
    assign load_value = (seed == '0) ? DEFAULT_SEED : seed;
`else
    assign load_value = seed;
`endif

    lfsr_core #(
        .WIDTH       (WIDTH),
        .TAPS        (TAPS),
        .RESET_VALUE (DEFAULT_SEED)
    ) u_core (
        .clock      (clock),
        .reset      (reset),
        .load       (seed_accept),
        .load_value (load_value),
        .advance    (handshake),
        .state      (challenge)
    );

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and Moore outputs; abort outranks a same-cycle final handshake.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
        state_d         = state_q;
        challenge_valid = 1'b0;
        busy            = 1'b0;
        done            = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_accept) begin
                    state_d = (burst_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                challenge_valid = 1'b1;
                busy            = 1'b1;
                if (abort) begin
                    state_d = IDLE;
                end else if (last_handshake) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Burst counters: reload on start, then track accepted challenges.
    always_ff @(posedge clock) begin
        if (reset) begin
            remaining_q <= '0;
            issued_q    <= '0;
        end else if (start_accept) begin
            remaining_q <= burst_len;
            issued_q    <= '0;
        end else if (handshake) begin
            remaining_q <= remaining_q - CNT_W'(1);
            issued_q    <= issued_q + CNT_W'(1);
        end
    end

    assign issued_count = issued_q;

`ifdef LFSR_LOCKUP_RECOVER_EN
    logic lockup_q;

    // Flag the cycle after a zero seed was replaced.
    always_ff @(posedge clock) begin
        if (reset) begin
            lockup_q <= 1'b0;
        end else begin
            lockup_q <= seed_accept && (seed == '0);
        end
    end

    assign lockup_fixed = lockup_q;
`endif

endmodule

// File: tb/tb_lfsr_challenge_gen.sv
// Self-checking bench for lfsr_challenge_gen (WIDTH=8, TAPS=8'h8E).
// Works with and without LFSR_LOCKUP_RECOVER_EN defined.
module tb_lfsr_challenge_gen;

    localparam logic [7:0] TAPS = 8'h8E;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  seed;
    logic        seed_load;
    logic        start;
    logic [15:0] burst_len;
    logic        abort;
    logic [7:0]  challenge;
    logic        challenge_valid;
    logic        challenge_ready;
    logic        busy;
    logic        done;
    logic [15:0] issued_count;
`ifdef LFSR_LOCKUP_RECOVER_EN
    logic        lockup_fixed;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: expected LFSR contents and accepted count of the current burst.
    logic [7:0] m_state;
    int         m_issued;

    lfsr_challenge_gen #(
        .WIDTH        (8),
        .TAPS         (8'h8E),
        .CNT_W        (16),
        .DEFAULT_SEED (8'h01)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .seed            (seed),
        .seed_load       (seed_load),
        .start           (start),
        .burst_len       (burst_len),
        .abort           (abort),
        .challenge       (challenge),
        .challenge_valid (challenge_valid),
        .challenge_ready (challenge_ready),
        .busy            (busy),
        .done            (done),
`ifdef LFSR_LOCKUP_RECOVER_EN
        .lockup_fixed    (lockup_fixed),
`endif
        .issued_count    (issued_count)
    );

    always #5 clock = ~clock;

    // Hard stop in case something wedges outside the bounded loops.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Double the value modulo 256 and add the parity of the tapped bits.
    function automatic logic [7:0] model_next(input logic [7:0] s);
        int fb;
        fb = $countones(s & TAPS) % 2;
        return 8'(((int'(s) * 2) % 256) + fb);
    endfunction

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Load a seed in IDLE, sometimes together with start (the load must win).
    task automatic load_seed(input logic [7:0] v);
        seed      = v;
        seed_load = 1'b1;
        start     = 1'($urandom % 2);
        burst_len = 16'($urandom_range(1, 5));
        step();
        seed_load = 1'b0;
        start     = 1'b0;
        m_state   = v;
`ifdef LFSR_LOCKUP_RECOVER_EN
        if (v == 8'h00) m_state = 8'h01;
`endif
        check("load_challenge", challenge, m_state);
        check("load_busy", busy, 0);
        check("load_valid", challenge_valid, 0);
        check("load_issued", issued_count, m_issued);
`ifdef LFSR_LOCKUP_RECOVER_EN
        check("lockup_pulse", lockup_fixed, (v == 8'h00));
        step();
        check("lockup_end", lockup_fixed, 0);
`endif
    endtask

    // Run one burst. mode: 0 ready always, 1 ready toggling, 2 random ready.
    // abort_at: handshake count at which abort is raised (-1 for none). noise: poke seed_load/start during RUN.
    task automatic do_burst(input int len, input int mode, input int abort_at, input bit noise);
        int hs;
        int cyc;
        bit finished;
        bit aborting;
        hs       = 0;
        cyc      = 0;
        finished = 1'b0;
        aborting = 1'b0;
        burst_len = 16'(len);
        start     = 1'b1;
        step();
        start     = 1'b0;
        burst_len = 16'($urandom);
        m_issued  = 0;
        check("start_issued_clear", issued_count, 0);
        check("start_busy", busy, 1);
        if (len == 0) begin
            // Empty burst: straight to the done cycle, never offering a challenge.
            check("zero_valid", challenge_valid, 0);
            check("zero_done", done, 1);
            step();
            check("zero_done_end", done, 0);
            check("zero_busy_end", busy, 0);
            check("zero_state", challenge, m_state);
            return;
        end
        while (!finished && cyc < 500) begin
            check("run_valid", challenge_valid, 1);
            check("run_busy", busy, 1);
            check("run_done_low", done, 0);
            check("run_challenge", challenge, m_state);
            case (mode)
                0:       challenge_ready = 1'b1;
                1:       challenge_ready = (cyc % 2 == 0);
                default: challenge_ready = 1'($urandom % 2);
            endcase
            aborting = (hs == abort_at);
            abort    = aborting;
            if (aborting && mode != 2) challenge_ready = 1'b0;
            if (noise) begin
                seed      = 8'($urandom);
                seed_load = ($urandom % 3 == 0);
                start     = ($urandom % 3 == 0);
            end
            if (challenge_ready) begin
                m_state = model_next(m_state);
                m_issued++;
                hs++;
            end
            step();
            abort           = 1'b0;
            challenge_ready = 1'b0;
            seed_load       = 1'b0;
            start           = 1'b0;
            cyc++;
            if (aborting) begin
                finished = 1'b1;
                check("abort_valid", challenge_valid, 0);
                check("abort_done", done, 0);
                check("abort_busy", busy, 0);
                check("abort_issued", issued_count, m_issued);
            end else if (hs == len) begin
                finished = 1'b1;
                check("last_valid", challenge_valid, 0);
                check("last_done", done, 1);
                check("last_busy", busy, 1);
                check("last_issued", issued_count, len);
                step();
                check("done_end", done, 0);
                check("done_busy_end", busy, 0);
            end
        end
        check("burst_finished", finished, 1);
        check("burst_state", challenge, m_state);
    endtask

    initial begin
        int len;
        int ab;
        reset           = 1'b1;
        seed            = 8'h00;
        seed_load       = 1'b0;
        start           = 1'b0;
        burst_len       = 16'h0;
        abort           = 1'b0;
        challenge_ready = 1'b0;
        m_state         = 8'h01;
        m_issued        = 0;
        step();
        step();
        reset = 1'b0;

        // Reset values.
        check("reset_challenge", challenge, 8'h01);
        check("reset_valid", challenge_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_issued", issued_count, 0);

        // Seed 01, four challenges with ready held high: 01,02,05,0B then state 16.
        load_seed(8'h01);
        do_burst(4, 0, -1, 1'b0);
        check("seq_state_16", challenge, 8'h16);

        // Same burst with ready toggling; challenge must hold while not accepted.
        load_seed(8'h01);
        do_burst(4, 1, -1, 1'b0);
        check("toggle_issued_4", issued_count, 16'd4);

        // Next burst continues the sequence from 16 without a reload.
        do_burst(1, 0, -1, 1'b0);
        check("single_issued_1", issued_count, 16'd1);

        // Abort after the first handshake: no done, one issued, state 02.
        load_seed(8'h01);
        do_burst(3, 0, 1, 1'b0);
        check("abort_state_02", challenge, 8'h02);
        check("abort_issued_1", issued_count, 16'd1);

        // Empty burst.
        do_burst(0, 0, -1, 1'b0);

        // Seed loads and starts during RUN/DONE are ignored.
        load_seed(8'($urandom_range(1, 255)));
        do_burst(5, 2, -1, 1'b1);

        // Reset in the middle of a burst returns to reset values with no done.
        load_seed(8'h5A);
        burst_len = 16'd5;
        start     = 1'b1;
        step();
        start           = 1'b0;
        challenge_ready = 1'b1;
        step();
        step();
        reset = 1'b1;
        step();
        reset           = 1'b0;
        challenge_ready = 1'b0;
        m_state         = 8'h01;
        m_issued        = 0;
        check("midreset_challenge", challenge, m_state);
        check("midreset_valid", challenge_valid, 0);
        check("midreset_busy", busy, 0);
        check("midreset_done", done, 0);
        check("midreset_issued", issued_count, 0);
        step();
        check("midreset_no_done", done, 0);

        // Randomised bursts: random seeds, lengths, ready patterns and aborts.
        for (int i = 0; i < 10; i++) begin
            load_seed(8'($urandom_range(1, 255)));
            len = $urandom_range(0, 6);
            ab  = (len > 0 && ($urandom % 3 == 0)) ? $urandom_range(0, len - 1) : -1;
            do_burst(len, 2, ab, 1'($urandom % 2));
        end

        // Zero seed: stuck at 00 by default, replaced by 01 when recovery is enabled.
        load_seed(8'h00);
        do_burst(3, 0, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
